// File: rtl/ifetch_unit.sv
// ifetch_unit -- instruction-fetch front end.
//
// Owns the program counter and drives the instruction-memory address. The
// instruction memory returns its word in the same cycle. The word and its PC
// are captured into a 2-entry fetch buffer. The buffer head is offered to
// decode over a valid/ready handshake.
//
// Optional feature macro: FETCH_MISALIGN_EN
//   defined   : a misaligned redirect target produces a single fault entry
//               and fetch halts until the next redirect or reset.
//   undefined : redirect targets are forced word-aligned; id_fault is 0.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   iaddr        out  [31:0] instruction byte address (the PC register)
//   idata        in   [31:0] instruction word at iaddr, same cycle
//   redirect     in   flush the buffer and restart fetch at redirect_pc
//   redirect_pc  in   [31:0] redirect target
//   id_valid     out  buffer head valid
//   id_ready     in   decode consumes the head this cycle
//   id_instr     out  [31:0] head instruction (0 when empty)
//   id_pc        out  [31:0] head PC (0 when empty)
//   id_pc4       out  [31:0] head PC + 4 (0 when empty)
//   id_fault     out  head is a misaligned-target fault entry
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_fault
);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  // Entry 0 is always the head; entry 1 shifts down on a pop.
  logic [31:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
  logic [31:0] e0_instr_q, e0_instr_d, e1_instr_q, e1_instr_d;
  logic [31:0] new_instr;
  logic        push, pop, halted;

`ifdef FETCH_MISALIGN_EN
  logic halted_q, halted_d;
  logic e0_fault_q, e0_fault_d, e1_fault_q, e1_fault_d;
  logic fault_fetch;

  // The PC can only become misaligned through a redirect, so a misaligned
  // PC while not halted marks the one cycle that emits the fault entry.
  assign fault_fetch = (pc_q[1:0] != 2'b00);
  assign halted      = halted_q;
  assign new_instr   = fault_fetch ? 32'h0 : idata;
`else
  assign halted      = 1'b0;
  assign new_instr   = idata;
`endif

  // Push depends only on registered state, never on id_ready.
  assign pop  = (count_q != 2'd0) && id_ready;
  assign push = !redirect && !halted && (count_q != 2'd2);

  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    e0_pc_d    = e0_pc_q;
    e1_pc_d    = e1_pc_q;
    e0_instr_d = e0_instr_q;
    e1_instr_d = e1_instr_q;
`ifdef FETCH_MISALIGN_EN
    halted_d   = halted_q;
    e0_fault_d = e0_fault_q;
    e1_fault_d = e1_fault_q;
`endif
    if (redirect) begin
      // Flush wins over any pop or push in the same cycle.
      count_d = 2'd0;
`ifdef FETCH_MISALIGN_EN
      halted_d = 1'b0;
      pc_d     = redirect_pc;
`else
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
`endif
    end else begin
      if (push) begin
`ifdef FETCH_MISALIGN_EN
        if (fault_fetch) halted_d = 1'b1;
        else             pc_d     = pc_q + 32'd4;
`else
        pc_d = pc_q + 32'd4;
`endif
      end
      case ({push, pop})
        2'b01: begin
          e0_pc_d    = e1_pc_q;
          e0_instr_d = e1_instr_q;
`ifdef FETCH_MISALIGN_EN
          e0_fault_d = e1_fault_q;
`endif
          count_d    = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_pc_d    = pc_q;
            e0_instr_d = new_instr;
`ifdef FETCH_MISALIGN_EN
            e0_fault_d = fault_fetch;
`endif
          end else begin
            e1_pc_d    = pc_q;
            e1_instr_d = new_instr;
`ifdef FETCH_MISALIGN_EN
            e1_fault_d = fault_fetch;
`endif
          end
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          // Push only happens with count < 2 and pop needs count > 0,
          // so count is 1 here: the new word replaces the departing head.
          e0_pc_d    = pc_q;
          e0_instr_d = new_instr;
`ifdef FETCH_MISALIGN_EN
          e0_fault_d = fault_fetch;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      e0_pc_q    <= 32'h0;
      e1_pc_q    <= 32'h0;
      e0_instr_q <= 32'h0;
      e1_instr_q <= 32'h0;
`ifdef FETCH_MISALIGN_EN
      halted_q   <= 1'b0;
      e0_fault_q <= 1'b0;
      e1_fault_q <= 1'b0;
`endif
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      e0_pc_q    <= e0_pc_d;
      e1_pc_q    <= e1_pc_d;
      e0_instr_q <= e0_instr_d;
      e1_instr_q <= e1_instr_d;
`ifdef FETCH_MISALIGN_EN
      halted_q   <= halted_d;
      e0_fault_q <= e0_fault_d;
      e1_fault_q <= e1_fault_d;
`endif
    end
  end

  assign iaddr    = pc_q;
  assign id_valid = (count_q != 2'd0);
  assign id_instr = id_valid ? e0_instr_q : 32'h0;
  assign id_pc    = id_valid ? e0_pc_q : 32'h0;
  assign id_pc4   = id_valid ? (e0_pc_q + 32'd4) : 32'h0;
`ifdef FETCH_MISALIGN_EN
  assign id_fault = id_valid & e0_fault_q;
`else
  assign id_fault = 1'b0;
`endif

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch front end of the pipeline. It owns the program counter, drives the instruction-memory address, and captures the returned instruction word with its PC into a 2-entry fetch buffer. The buffer feeds the decode stage over a valid/ready handshake. It sits between the instruction memory (combinational read: `idata` is valid in the same cycle as `iaddr`) and the IF/ID boundary, and accepts branch/jump redirects from later stages.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.

Ports:
- `clk`, input, 1: the only clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `iaddr`, output, 32: instruction-memory byte address; equals the PC register.
- `idata`, input, 32: instruction word at `iaddr`, same cycle.
- `redirect`, input, 1: flush the pipeline and restart fetch at `redirect_pc`.
- `redirect_pc`, input, 32: redirect target byte address.
- `id_valid`, output, 1: fetch-buffer head is valid.
- `id_ready`, input, 1: decode accepts the head this cycle.
- `id_instr`, output, 32: head instruction word.
- `id_pc`, output, 32: head PC.
- `id_pc4`, output, 32: head PC + 4, modulo 2^32.
- `id_fault`, output, 1: head is a misaligned-target fault entry (see Configuration).

## Operation
- State:
  - `pc` (32 bits).
  - 2-entry FIFO of {pc, instr, fault}.
  - `count` (0..2).
  - `halted` flag (only used when the macro is enabled).
- Pop: `id_valid && id_ready`. The head is removed.
- Push: `!redirect && !halted && count < 2`.
  - Writes {`pc`, `idata`, 0} to the tail.
  - `pc <= pc + 4`, wrapping `32'hFFFF_FFFC -> 32'h0000_0000`.
- The full test uses the registered `count` only. There is no combinational path from `id_ready` to the push decision.
- Push and pop in the same cycle: `count` is unchanged and FIFO order is preserved.
- Redirect has priority over everything else in its cycle:
  - FIFO cleared (`count <= 0`); any pop that cycle is discarded.
  - No push.
  - `pc <= redirect_pc`.
  - `halted <= 0`.
- Output masking:
  - `id_valid = (count != 0)`.
  - When `count == 0`: `id_instr`, `id_pc`, `id_pc4` and `id_fault` are all 0.
- Reset (asynchronous, `rst` low):
  - `pc = RESET_PC`, so `iaddr = RESET_PC`.
  - `count = 0`, `halted = 0`, all FIFO entries 0.
  - `id_valid = 0`, `id_instr = 0`, `id_pc = 0`, `id_pc4 = 0`, `id_fault = 0`.
  - Reset asserted mid-stream discards all buffered entries immediately.

## Timing
- Fetch-to-decode latency: 1 cycle. An instruction addressed in cycle N appears at the head in cycle N+1 if the FIFO was empty.
- After reset release at edge E, `RESET_PC` is fetched in the cycle following E; `id_valid` rises one edge later.
- Redirect sampled at edge N:
  - `id_valid = 0` in cycle N+1.
  - `iaddr = target` in cycle N+1.
  - Target instruction at the head in cycle N+2 (2-cycle bubble).
- Throughput: one instruction per cycle while `id_ready = 1` (steady-state `count = 1`).
- With `id_ready = 0`: the FIFO fills to 2 and `pc` then holds; `iaddr` stays stable until a pop frees a slot.

## Configuration
- Macro: `FETCH_MISALIGN_EN`.
- Defined:
  - A redirect with `redirect_pc[1:0] != 0` flushes as usual and sets `pc <= redirect_pc`.
  - In the next cycle it pushes a single fault entry {`redirect_pc`, `32'h0`, 1} instead of a fetch, then sets `halted <= 1`.
  - While halted: no pushes, `pc` frozen. Only a later redirect or reset clears `halted`.
- Undefined:
  - Redirect target is forced aligned: `pc <= {redirect_pc[31:2], 2'b00}`.
  - `halted` is never set; `id_fault` is tied to 0.

## Test plan
- Reset release with `RESET_PC = 0`, `idata` = address-derived pattern, `id_ready = 1` -> `id_pc` sequence 0, 4, 8, …, one per cycle; `id_pc4 = id_pc + 4`; first `id_valid` exactly 2 edges after reset release.
- Hold `id_ready = 0` for 5 cycles, then 1 -> `count` saturates at 2; `iaddr` frozen at 0x8 after entries 0x0/0x4; resumes in order 0x0, 0x4, 0x8 with no loss or duplication.
- `redirect = 1`, `redirect_pc = 0x100` while the FIFO holds 2 entries and `id_ready = 1` -> no pop delivered that cycle; `id_valid = 0` next cycle; head `id_pc = 0x100` one cycle later.
- `pc = 32'hFFFF_FFF8` -> `id_pc` sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; `id_pc4` at 0xFFFFFFFC equals 0.
- With `FETCH_MISALIGN_EN`: redirect to 0x102 -> a single head entry {`id_pc = 0x102`, `id_fault = 1`, `id_instr = 0`}, then no further pushes; a redirect to 0x200 resumes normal fetch. Without the macro: the same stimulus yields `id_pc = 0x100`, `id_fault = 0`.
- Assert `rst` low mid-stream with 2 entries buffered -> `id_valid = 0` and `iaddr = RESET_PC` immediately, without waiting for a clock edge.
